// File: rtl/game_pkg.sv
// Shared types and defaults for the game input controller: debouncer state
// encoding, default debounce length and the debounce counter sizing helper.
package game_pkg;

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HI      = 2'd2,
    S_WAIT_LO = 2'd3
  } deb_state_e;

  // 10 ms of stability at a 50 MHz board clock
  localparam int DEB_CYCLES_DEFAULT = 500000;

  function automatic int deb_cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer followed by a 4-state debounce FSM whose
// registered output is the accepted (stable) button level.
module btn_debounce import game_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic board_clk,
  input  logic reset,
  input  logic btn_i,
  output logic db_o
);

  localparam int CW = deb_cnt_width(DEB_CYCLES);
  // The switch happens on the edge where the count would reach DEB_CYCLES-1,
  // so the level is accepted after exactly DEB_CYCLES matching samples.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 2);

  logic [1:0]      sync_q;
  deb_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic            db_q;
  logic            sample;

  assign sample = sync_q[1];
  assign db_o   = db_q;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= S_LO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      case (state_q)
        S_LO: begin
          if (sample) begin
            state_q <= S_WAIT_HI;
            cnt_q   <= '0;
          end
        end
        S_WAIT_HI: begin
          if (!sample) begin
            state_q <= S_LO;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_HI;
            db_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HI: begin
          if (!sample) begin
            state_q <= S_WAIT_LO;
            cnt_q   <= '0;
          end
        end
        S_WAIT_LO: begin
          if (sample) begin
            state_q <= S_HI;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_LO;
            db_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_LO;
          cnt_q   <= '0;
          db_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/game_input_ctrl.sv
// Game input front end: debounces left/right/fire buttons, derives exclusive
// move levels and turns fire presses into tick-aligned, gated shot strobes.
module game_input_ctrl import game_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = 8
) (
  input  logic             board_clk,
  input  logic             reset,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic             btn_u,
  input  logic             tick_en,
  input  logic             shot_busy,
  output logic             move_left,
  output logic             move_right,
  output logic             fire_pulse,
  output logic [CNT_W-1:0] shot_count,
  output logic [2:0]       btn_db
);

  logic [2:0]       db;
  logic             move_left_q, move_right_q, fire_q, pending_q, db_u_prev_q;
  logic [CNT_W-1:0] count_q;
  logic             fire_rise, shot_req, fire_ok, fire_d, pending_d;
  logic [CNT_W-1:0] count_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .board_clk(board_clk), .reset(reset), .btn_i(btn_l), .db_o(db[0])
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .board_clk(board_clk), .reset(reset), .btn_i(btn_r), .db_o(db[1])
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_u (
    .board_clk(board_clk), .reset(reset), .btn_i(btn_u), .db_o(db[2])
  );

  // Any pressed direction button blocks a shot, including the case where
  // left and right cancel each other out and both move levels are low.
  always_comb begin
    fire_rise = db[2] & ~db_u_prev_q;
    shot_req  = pending_q | fire_rise;
    fire_ok   = ~shot_busy & ~move_left_q & ~move_right_q & ~db[0] & ~db[1];
    fire_d    = tick_en & shot_req & fire_ok;
    pending_d = tick_en ? 1'b0 : shot_req;
    count_d   = (fire_d && (count_q != '1)) ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      fire_q       <= 1'b0;
      pending_q    <= 1'b0;
      db_u_prev_q  <= 1'b0;
      count_q      <= '0;
    end else begin
      move_left_q  <= db[0] & ~db[1];
      move_right_q <= db[1] & ~db[0];
      fire_q       <= fire_d;
      pending_q    <= pending_d;
      db_u_prev_q  <= db[2];
      count_q      <= count_d;
    end
  end

  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign fire_pulse = fire_q;
  assign shot_count = count_q;
  assign btn_db     = db;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Self-checking bench for game_input_ctrl with a short debounce window; shot
// strobes are checked against a scoreboard filled when ticks are driven.
module tb_game_input_ctrl;

   localparam int DEB = 8;

   typedef struct {
      int cyc;
      int cnt8;
      int cnt2;
   } fireExp_t;

   logic       boardClk;
   logic       reset;
   logic       btnL, btnR, btnU, tickEn, shotBusy;
   logic       moveLeft, moveRight, firePulse;
   logic [7:0] shotCount;
   logic [2:0] btnDb;
   logic       moveLeft2, moveRight2, firePulse2;
   logic [1:0] shotCount2;
   logic [2:0] btnDb2;

   int         cyc;
   int         modelCount;
   int         assertCount;
   int         failCount;
   fireExp_t   sbQueue[$];

   game_input_ctrl #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
      .board_clk(boardClk), .reset(reset), .btn_l(btnL), .btn_r(btnR),
      .btn_u(btnU), .tick_en(tickEn), .shot_busy(shotBusy),
      .move_left(moveLeft), .move_right(moveRight), .fire_pulse(firePulse),
      .shot_count(shotCount), .btn_db(btnDb)
   );

   game_input_ctrl #(.DEB_CYCLES(DEB), .CNT_W(2)) dutSat (
      .board_clk(boardClk), .reset(reset), .btn_l(btnL), .btn_r(btnR),
      .btn_u(btnU), .tick_en(tickEn), .shot_busy(shotBusy),
      .move_left(moveLeft2), .move_right(moveRight2), .fire_pulse(firePulse2),
      .shot_count(shotCount2), .btn_db(btnDb2)
   );

   // Free-running board clock, 10 time units per period
   initial begin
      boardClk = 1'b0;
      forever #5 boardClk = ~boardClk;
   end

   // Edge counter used to time-stamp expected and observed fire strobes
   always @(posedge boardClk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic l, input logic r, input logic u, input logic busy);
      btnL     = l;
      btnR     = r;
      btnU     = u;
      shotBusy = busy;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge boardClk);
   endtask

   // One-cycle tick; an accepted shot is expected one edge after the tick edge
   task automatic pulseTick(input bit expectFire);
      fireExp_t e;
      tickEn = 1'b1;
      if (expectFire) begin
         modelCount++;
         e.cyc  = cyc + 1;
         e.cnt8 = (modelCount > 255) ? 255 : modelCount;
         e.cnt2 = (modelCount > 3) ? 3 : modelCount;
         sbQueue.push_back(e);
      end
      @(negedge boardClk);
      tickEn = 1'b0;
   endtask

   // Scoreboard consumer: every strobe must match the head entry, and a head
   // entry whose cycle has passed without a strobe is reported as missing
   always @(negedge boardClk) begin
      if (!reset) begin
         if (firePulse === 1'b1) begin
            if (sbQueue.size() == 0) begin
               checkOutput("fire_unexpected", 32'(firePulse), 32'd0);
            end else begin
               fireExp_t e;
               e = sbQueue.pop_front();
               checkOutput("fire_cycle", cyc, e.cyc);
               checkOutput("fire_count", 32'(shotCount), e.cnt8);
               checkOutput("fire_count_sat", 32'(shotCount2), e.cnt2);
               checkOutput("fire_pulse_sat", 32'(firePulse2), 32'd1);
            end
         end else if (sbQueue.size() > 0 && cyc >= sbQueue[0].cyc) begin
            void'(sbQueue.pop_front());
            checkOutput("fire_missing", 32'(firePulse), 32'd1);
         end
      end
   end

   initial begin
      assertCount = 0;
      failCount   = 0;
      modelCount  = 0;
      reset       = 1'b1;
      tickEn      = 1'b0;
      applyStimulus(0, 0, 0, 0);
      waitCycles(3);
      checkOutput("rst_btn_db", 32'(btnDb), 32'd0);
      checkOutput("rst_moves", 32'({moveLeft, moveRight}), 32'd0);
      checkOutput("rst_fire", 32'(firePulse), 32'd0);
      checkOutput("rst_count", 32'(shotCount), 32'd0);
      reset = 1'b0;

      // Clean press on right: debounced at edge 10, move level at edge 11
      applyStimulus(0, 1, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         @(negedge boardClk);
         checkOutput("press_db_r", 32'(btnDb[1]), 32'(i >= DEB + 2));
         checkOutput("press_move_r", 32'(moveRight), 32'(i >= DEB + 3));
      end
      waitCycles(8);
      applyStimulus(0, 0, 0, 0);
      waitCycles(12);
      checkOutput("release_db_r", 32'(btnDb[1]), 32'd0);
      checkOutput("release_move_r", 32'(moveRight), 32'd0);

      // Bouncing left button never gets through
      for (int i = 0; i < 45; i++) begin
         btnL = (i < 30) && ((i / 3) % 2 == 0);
         @(negedge boardClk);
         checkOutput("bounce_db_l", 32'(btnDb[0]), 32'd0);
         checkOutput("bounce_move_l", 32'(moveLeft), 32'd0);
      end

      // Fire: one shot per press, ticks while held do nothing more
      applyStimulus(0, 0, 1, 0);
      waitCycles(DEB + 1);
      checkOutput("fire_db_u_early", 32'(btnDb[2]), 32'd0);
      waitCycles(1);
      checkOutput("fire_db_u", 32'(btnDb[2]), 32'd1);
      waitCycles(5);
      pulseTick(1);
      waitCycles(3);
      for (int i = 0; i < 3; i++) begin
         pulseTick(0);
         waitCycles(2);
      end
      checkOutput("fire_held_count", 32'(shotCount), 32'd1);
      applyStimulus(0, 0, 0, 0);
      waitCycles(12);

      // Drop: busy at tick discards the shot and clears pending
      applyStimulus(0, 0, 1, 0);
      waitCycles(DEB + 3);
      shotBusy = 1'b1;
      pulseTick(0);
      shotBusy = 1'b0;
      waitCycles(3);
      pulseTick(0);
      waitCycles(3);
      checkOutput("drop_count", 32'(shotCount), 32'd1);
      applyStimulus(0, 0, 0, 0);
      waitCycles(12);

      // Both directions held: moves cancel and a fire press is dropped
      applyStimulus(1, 1, 0, 0);
      waitCycles(DEB + 4);
      checkOutput("both_db", 32'(btnDb[1:0]), 32'd3);
      checkOutput("both_moves", 32'({moveLeft, moveRight}), 32'd0);
      btnU = 1'b1;
      waitCycles(DEB + 3);
      pulseTick(0);
      waitCycles(3);
      checkOutput("both_count", 32'(shotCount), 32'd1);
      applyStimulus(0, 0, 0, 0);
      waitCycles(12);

      // Debounced fire edge landing on the tick cycle is serviced directly
      applyStimulus(0, 0, 1, 0);
      waitCycles(DEB + 2);
      checkOutput("edge_tick_db_u", 32'(btnDb[2]), 32'd1);
      pulseTick(1);
      waitCycles(3);
      applyStimulus(0, 0, 0, 0);
      waitCycles(12);

      // Three more shots drive the 2-bit counter into saturation
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 0);
         waitCycles(DEB + 4);
         pulseTick(1);
         waitCycles(3);
         applyStimulus(0, 0, 0, 0);
         waitCycles(12);
      end
      checkOutput("sat_count_wide", 32'(shotCount), 32'd5);
      checkOutput("sat_count_narrow", 32'(shotCount2), 32'd3);

      // Reset with a shot pending and right mid-debounce
      applyStimulus(0, 0, 1, 0);
      waitCycles(DEB + 4);
      btnR = 1'b1;
      waitCycles(5);
      #2 reset = 1'b1;
      #1;
      checkOutput("mid_rst_btn_db", 32'({btnDb, btnDb2}), 32'd0);
      checkOutput("mid_rst_moves", 32'({moveLeft, moveRight, moveLeft2, moveRight2}), 32'd0);
      checkOutput("mid_rst_fire", 32'({firePulse, firePulse2}), 32'd0);
      checkOutput("mid_rst_count", 32'({shotCount, shotCount2}), 32'd0);
      applyStimulus(0, 0, 0, 0);
      modelCount = 0;
      waitCycles(2);
      reset = 1'b0;
      waitCycles(DEB + 4);
      pulseTick(0);
      waitCycles(3);
      checkOutput("post_rst_db_r", 32'(btnDb[1]), 32'd0);
      checkOutput("post_rst_count", 32'(shotCount), 32'd0);

      checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
